// File: rtl/dca_matrix_pkg.sv
// Shared widths, state encoding and helpers for the
// DCA matrix block row requester.
package dca_matrix_pkg;

   localparam int DCA_MATRIX_NUM_ROW  = 8;
   localparam int DCA_MATRIX_NUM_COL  = 8;
   localparam int DCA_BW_ADDR         = 32;
   localparam int DCA_BW_STRIDE       = 16;
   localparam int DCA_BW_ELEM_LOG2    = 3;
   localparam int DCA_MAX_OUTSTANDING = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } dca_req_state_e;

   // Bits needed to index v items; never less than one.
   function automatic int LOG2RU(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/dca_outstanding_counter.sv
// In-flight read tracker: up/down counter with limit
// compare and underflow check.
module dca_outstanding_counter
   import dca_matrix_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DCA_MAX_OUTSTANDING
) (
   input  logic clk,
   input  logic rstnn,
   input  logic clear_i,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o
);

   localparam int CW = LOG2RU(MAX_OUTSTANDING + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (inc_i && !dec_i)
         cnt_d = cnt_q + CW'(1);
      else if (dec_i && !inc_i && cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign full_o = (cnt_q >= CW'(MAX_OUTSTANDING));

   a_no_underflow: assert property (
      @(posedge clk) disable iff (!rstnn)
      !(dec_i && !clear_i && cnt_q == '0)
   );

endmodule

// File: rtl/dca_matrix_block_row_requester.sv
// Issues one read per valid row of an accepted block
// descriptor and pulses block_done after the last response.
module dca_matrix_block_row_requester
   import dca_matrix_pkg::*;
#(
   parameter int MATRIX_NUM_ROW  = DCA_MATRIX_NUM_ROW,
   parameter int MATRIX_NUM_COL  = DCA_MATRIX_NUM_COL,
   parameter int BW_ADDR         = DCA_BW_ADDR,
   parameter int BW_STRIDE       = DCA_BW_STRIDE,
   parameter int BW_ELEM_LOG2    = DCA_BW_ELEM_LOG2,
   parameter int MAX_OUTSTANDING = DCA_MAX_OUTSTANDING
) (
   input  logic                              clk,
   input  logic                              rstnn,
   input  logic                              clear,
   input  logic                              blk_valid,
   output logic                              blk_ready,
   input  logic [BW_ADDR-1:0]                blk_addr,
   input  logic [BW_STRIDE-1:0]              blk_stride,
   input  logic [LOG2RU(MATRIX_NUM_ROW)-1:0] blk_num_row_m1,
   input  logic [LOG2RU(MATRIX_NUM_COL)-1:0] blk_num_col_m1,
   input  logic [BW_ELEM_LOG2-1:0]           blk_elem_log2,
   output logic                              req_valid,
   input  logic                              req_ready,
   output logic [BW_ADDR-1:0]                req_addr,
   output logic [BW_ADDR-1:0]                req_bytes,
   output logic [LOG2RU(MATRIX_NUM_ROW)-1:0] req_row,
   output logic                              req_last,
   input  logic                              rsp_valid,
   output logic [LOG2RU(MATRIX_NUM_ROW)-1:0] rsp_row,
   output logic                              rsp_last,
   output logic                              block_done,
   output logic                              busy
);

   localparam int RW = LOG2RU(MATRIX_NUM_ROW);
   localparam int CW = LOG2RU(MATRIX_NUM_COL);

   dca_req_state_e          state_q, state_d;
   logic [BW_ADDR-1:0]      row_addr_q, row_addr_d;
   logic [BW_STRIDE-1:0]    stride_q, stride_d;
   logic [RW-1:0]           nrm1_q, nrm1_d;
   logic [CW-1:0]           ncm1_q, ncm1_d;
   logic [BW_ELEM_LOG2-1:0] elog_q, elog_d;
   logic [RW-1:0]           issue_row_q, issue_row_d;
   logic [RW-1:0]           rsp_cnt_q, rsp_cnt_d;
   logic                    done_q, done_d;

   logic               full;
   logic               in_issue;
   logic               req_fire;
   logic [BW_ADDR-1:0] row_bytes;

   assign in_issue  = (state_q == ST_ISSUE);
   assign busy      = (state_q != ST_IDLE);
   assign blk_ready = (state_q == ST_IDLE);
   assign req_valid = in_issue && !full;
   assign req_fire  = req_valid && req_ready;

   assign row_bytes =
      (BW_ADDR'(ncm1_q) + BW_ADDR'(1)) << elog_q;

   assign req_addr   = row_addr_q;
   assign req_row    = issue_row_q;
   assign req_bytes  = in_issue ? row_bytes : '0;
   assign req_last   = in_issue && (issue_row_q == nrm1_q);
   assign rsp_row    = rsp_cnt_q;
   assign rsp_last   = busy && (rsp_cnt_q == nrm1_q);
   assign block_done = done_q;

   always_comb begin
      state_d     = state_q;
      row_addr_d  = row_addr_q;
      stride_d    = stride_q;
      nrm1_d      = nrm1_q;
      ncm1_d      = ncm1_q;
      elog_d      = elog_q;
      issue_row_d = issue_row_q;
      rsp_cnt_d   = rsp_cnt_q;
      done_d      = 1'b0;
      if (clear) begin
         state_d     = ST_IDLE;
         issue_row_d = '0;
         rsp_cnt_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (blk_valid) begin
                  row_addr_d  = blk_addr;
                  stride_d    = blk_stride;
                  nrm1_d      = blk_num_row_m1;
                  ncm1_d      = blk_num_col_m1;
                  elog_d      = blk_elem_log2;
                  issue_row_d = '0;
                  rsp_cnt_d   = '0;
                  state_d     = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (req_fire) begin
                  row_addr_d  = row_addr_q + BW_ADDR'(stride_q);
                  issue_row_d = issue_row_q + RW'(1);
                  if (req_last) state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: ;
            default: state_d = ST_IDLE;
         endcase
         // Final response wins over any issue-side transition.
         if (busy && rsp_valid) begin
            rsp_cnt_d = rsp_cnt_q + RW'(1);
            if (rsp_last) begin
               rsp_cnt_d = '0;
               done_d    = 1'b1;
               state_d   = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q     <= ST_IDLE;
         row_addr_q  <= '0;
         stride_q    <= '0;
         nrm1_q      <= '0;
         ncm1_q      <= '0;
         elog_q      <= '0;
         issue_row_q <= '0;
         rsp_cnt_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_addr_q  <= row_addr_d;
         stride_q    <= stride_d;
         nrm1_q      <= nrm1_d;
         ncm1_q      <= ncm1_d;
         elog_q      <= elog_d;
         issue_row_q <= issue_row_d;
         rsp_cnt_q   <= rsp_cnt_d;
         done_q      <= done_d;
      end
   end

   dca_outstanding_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING)
   ) u_outstanding (
      .clk     (clk),
      .rstnn   (rstnn),
      .clear_i (clear),
      .inc_i   (req_fire),
      .dec_i   (rsp_valid),
      .full_o  (full)
   );

endmodule

// File: tb/tb_dca_matrix_block_row_requester.sv
// Directed bench for the block row requester with an
// in-order memory responder and a row-count model.
module tb_dca_matrix_block_row_requester;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rstnn;
   logic        clear;
   logic        blk_valid;
   logic        blk_ready;
   logic [31:0] blk_addr;
   logic [15:0] blk_stride;
   logic [2:0]  blk_num_row_m1;
   logic [2:0]  blk_num_col_m1;
   logic [2:0]  blk_elem_log2;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_bytes;
   logic [2:0]  req_row;
   logic        req_last;
   logic        rsp_valid;
   logic [2:0]  rsp_row;
   logic        rsp_last;
   logic        block_done;
   logic        busy;

   dca_matrix_block_row_requester #(
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk            (clk),
      .rstnn          (rstnn),
      .clear          (clear),
      .blk_valid      (blk_valid),
      .blk_ready      (blk_ready),
      .blk_addr       (blk_addr),
      .blk_stride     (blk_stride),
      .blk_num_row_m1 (blk_num_row_m1),
      .blk_num_col_m1 (blk_num_col_m1),
      .blk_elem_log2  (blk_elem_log2),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_bytes      (req_bytes),
      .req_row        (req_row),
      .req_last       (req_last),
      .rsp_valid      (rsp_valid),
      .rsp_row        (rsp_row),
      .rsp_last       (rsp_last),
      .block_done     (block_done),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   int unsigned cyc = 0;
   int unsigned done_cyc = 0;
   int unsigned lrsp_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h",
                  nm, act, exp);
      end
   endtask

   // Memory: in-order responses, mem_lat cycles after each
   // handshake, gated by a release budget.
   typedef struct {
      logic [31:0] addr;
      logic [31:0] bytes;
      int          row;
      bit          last;
   } req_t;

   req_t        log_q[$];
   int unsigned due_q[$];
   int unsigned mem_lat = 2;
   int          mem_budget = 1000;

   initial begin
      bit   fire;
      bit   flush;
      req_t r;
      rsp_valid = 1'b0;
      forever begin
         @(negedge clk);
         fire  = req_valid && req_ready && rstnn && !clear;
         flush = clear || !rstnn;
         r.addr  = req_addr;
         r.bytes = req_bytes;
         r.row   = int'(req_row);
         r.last  = req_last;
         @(posedge clk);
         #1;
         if (flush || !rstnn) begin
            due_q.delete();
         end else if (fire) begin
            due_q.push_back(cyc + mem_lat);
            log_q.push_back(r);
         end
         rsp_valid = 1'b0;
         if (rstnn && due_q.size() > 0 && mem_budget > 0
             && due_q[0] <= cyc + 1) begin
            rsp_valid = 1'b1;
            void'(due_q.pop_front());
            mem_budget--;
         end
      end
   end

   // Model: rows issued and rows returned since acceptance.
   bit          m_busy = 0;
   bit          m_done = 0;
   int          m_iss = 0;
   int          m_ret = 0;
   logic [31:0] m_addr = '0;
   logic [15:0] m_stride = '0;
   int          m_nr = 0;
   int          m_nc = 0;
   int          m_el = 0;

   initial begin
      bit iss;
      bit ev;
      forever begin
         @(negedge clk);
         iss = m_busy && (m_iss <= m_nr);
         ev  = iss && ((m_iss - m_ret) < MAXO);
         if (block_done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (rsp_valid && rsp_last) lrsp_cyc = cyc;
         if (!rstnn) begin
            chk("rst busy", 32'(busy), 0);
            chk("rst blk_ready", 32'(blk_ready), 1);
            chk("rst req_valid", 32'(req_valid), 0);
            chk("rst req_bytes", req_bytes, 0);
            chk("rst req_last", 32'(req_last), 0);
            chk("rst rsp_last", 32'(rsp_last), 0);
            chk("rst rsp_row", 32'(rsp_row), 0);
            chk("rst block_done", 32'(block_done), 0);
            m_busy = 0;
            m_done = 0;
            m_iss  = 0;
            m_ret  = 0;
         end else begin
            chk("model busy", 32'(busy), 32'(m_busy));
            chk("model blk_ready", 32'(blk_ready), 32'(!m_busy));
            chk("model block_done", 32'(block_done), 32'(m_done));
            chk("model req_valid", 32'(req_valid), 32'(ev));
            if (iss) begin
               chk("model req_addr", req_addr,
                   m_addr + 32'(m_iss) * 32'(m_stride));
               chk("model req_row", 32'(req_row), 32'(m_iss));
               chk("model req_last", 32'(req_last),
                   32'(m_iss == m_nr));
               chk("model req_bytes", req_bytes,
                   32'((m_nc + 1) << m_el));
            end
            if (m_busy) begin
               chk("model rsp_row", 32'(rsp_row), 32'(m_ret));
               chk("model rsp_last", 32'(rsp_last),
                   32'(m_ret == m_nr));
            end
            m_done = 0;
            if (clear) begin
               m_busy = 0;
               m_iss  = 0;
               m_ret  = 0;
            end else if (!m_busy) begin
               if (blk_valid) begin
                  m_busy   = 1;
                  m_iss    = 0;
                  m_ret    = 0;
                  m_addr   = blk_addr;
                  m_stride = blk_stride;
                  m_nr     = int'(blk_num_row_m1);
                  m_nc     = int'(blk_num_col_m1);
                  m_el     = int'(blk_elem_log2);
               end
            end else begin
               if (ev && req_ready) m_iss++;
               if (rsp_valid) begin
                  if (m_ret == m_nr) begin
                     m_busy = 0;
                     m_done = 1;
                  end
                  m_ret++;
               end
            end
         end
      end
   end

   task automatic sync;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] a,
                       input logic [15:0] s,
                       input logic [2:0]  nr,
                       input logic [2:0]  nc,
                       input logic [2:0]  el);
      bit ok;
      ok = 0;
      blk_addr       = a;
      blk_stride     = s;
      blk_num_row_m1 = nr;
      blk_num_col_m1 = nc;
      blk_elem_log2  = el;
      blk_valid      = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (blk_ready) ok = 1;
      end
      chk("accept timeout", 32'(ok), 1);
      sync();
      blk_valid = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      bit seen;
      seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         @(negedge clk);
         if (block_done) seen = 1;
      end
      chk("done timeout", 32'(seen), 1);
      sync();
   endtask

   task automatic wait_log(input int n, input int lim);
      bit seen;
      seen = 0;
      for (int i = 0; i < lim && !seen; i++) begin
         @(negedge clk);
         if (log_q.size() >= n) seen = 1;
      end
      chk("request timeout", 32'(seen), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lasts;
      int saved;
      bit seen;
      rstnn          = 1'b0;
      clear          = 1'b0;
      blk_valid      = 1'b0;
      blk_addr       = '0;
      blk_stride     = '0;
      blk_num_row_m1 = '0;
      blk_num_col_m1 = '0;
      blk_elem_log2  = '0;
      req_ready      = 1'b1;
      #2;
      chk("reset blk_ready", 32'(blk_ready), 1);
      chk("reset busy", 32'(busy), 0);
      chk("reset req_valid", 32'(req_valid), 0);
      chk("reset req_addr", req_addr, 0);
      repeat (3) sync();
      rstnn = 1'b1;
      repeat (2) sync();

      // Full 8x8 block, 4-byte elements
      log_q.delete();
      send(32'h1000, 16'h40, 3'd7, 3'd7, 3'd2);
      wait_done(300);
      chk("full count", 32'(log_q.size()), 8);
      chk("full addr0", log_q[0].addr, 32'h1000);
      chk("full addr3", log_q[3].addr, 32'h10C0);
      chk("full addr7", log_q[7].addr, 32'h11C0);
      chk("full bytes0", log_q[0].bytes, 32);
      chk("full bytes7", log_q[7].bytes, 32);
      lasts = 0;
      foreach (log_q[i]) if (log_q[i].last) lasts++;
      chk("full last count", 32'(lasts), 1);
      chk("full last row7", 32'(log_q[7].last), 1);
      chk("full done latency", done_cyc, lrsp_cyc + 1);

      // Backpressure with responses withheld
      log_q.delete();
      @(negedge clk);
      #1 mem_budget = 0;
      sync();
      send(32'h2000, 16'h10, 3'd7, 3'd0, 3'd0);
      repeat (10) @(negedge clk);
      chk("bp issued", 32'(log_q.size()), 2);
      chk("bp req_valid", 32'(req_valid), 0);
      #1 mem_budget = 1;
      repeat (6) @(negedge clk);
      chk("bp issued after 1", 32'(log_q.size()), 3);
      chk("bp req_valid after 1", 32'(req_valid), 0);
      #1 mem_budget = 1000;
      sync();
      wait_done(300);

      // Stall with row 3 pending
      log_q.delete();
      send(32'h3000, 16'h100, 3'd7, 3'd3, 3'd1);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (req_valid && req_ready && req_row == 3'd2)
            seen = 1;
      end
      chk("stall reach row2", 32'(seen), 1);
      sync();
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall req_row", 32'(req_row), 3);
         chk("stall req_last", 32'(req_last), 0);
         chk("stall req_addr", req_addr, 32'h3300);
      end
      sync();
      req_ready = 1'b1;
      @(negedge clk);
      chk("stall release valid", 32'(req_valid), 1);
      chk("stall release row", 32'(req_row), 3);
      sync();
      wait_done(300);
      chk("stall count", 32'(log_q.size()), 8);
      chk("stall addr3", log_q[3].addr, 32'h3300);
      chk("stall bytes", log_q[0].bytes, 8);

      // Single-row block
      log_q.delete();
      mem_lat = 3;
      send(32'h4000, 16'h20, 3'd0, 3'd2, 3'd0);
      wait_done(100);
      chk("edge count", 32'(log_q.size()), 1);
      chk("edge bytes", log_q[0].bytes, 3);
      chk("edge last", 32'(log_q[0].last), 1);
      chk("edge row", 32'(log_q[0].row), 0);
      mem_lat = 2;

      // Address wrap, second descriptor held during block
      log_q.delete();
      send(32'hFFFF_FFC0, 16'h40, 3'd1, 3'd7, 3'd3);
      blk_addr       = 32'h5000;
      blk_stride     = 16'h8;
      blk_num_row_m1 = 3'd0;
      blk_num_col_m1 = 3'd0;
      blk_elem_log2  = 3'd0;
      blk_valid      = 1'b1;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (block_done) seen = 1;
      end
      chk("b2b first done", 32'(seen), 1);
      chk("b2b ready at done", 32'(blk_ready), 1);
      sync();
      blk_valid = 1'b0;
      @(negedge clk);
      chk("b2b second busy", 32'(busy), 1);
      sync();
      wait_done(100);
      chk("wrap count", 32'(log_q.size()), 3);
      chk("wrap addr0", log_q[0].addr, 32'hFFFF_FFC0);
      chk("wrap addr1", log_q[1].addr, 32'h0);
      chk("wrap bytes", log_q[0].bytes, 64);
      chk("b2b addr", log_q[2].addr, 32'h5000);

      // Clear in DRAIN with two outstanding
      log_q.delete();
      @(negedge clk);
      #1 mem_budget = 0;
      sync();
      send(32'h6000, 16'h40, 3'd1, 3'd0, 3'd0);
      wait_log(2, 50);
      chk("abort drain busy", 32'(busy), 1);
      chk("abort drain valid", 32'(req_valid), 0);
      saved = n_done;
      sync();
      clear = 1'b1;
      sync();
      clear = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(busy), 0);
      chk("abort blk_ready", 32'(blk_ready), 1);
      chk("abort block_done", 32'(block_done), 0);
      repeat (3) @(negedge clk);
      chk("abort no done", 32'(n_done), 32'(saved));
      #1 mem_budget = 1000;
      sync();

      // Asynchronous reset mid-ISSUE
      log_q.delete();
      send(32'h7000, 16'h40, 3'd7, 3'd7, 3'd2);
      wait_log(3, 50);
      saved = n_done;
      @(posedge clk);
      #3 rstnn = 1'b0;
      #1;
      chk("arst busy", 32'(busy), 0);
      chk("arst blk_ready", 32'(blk_ready), 1);
      chk("arst req_valid", 32'(req_valid), 0);
      chk("arst req_addr", req_addr, 0);
      chk("arst req_row", 32'(req_row), 0);
      chk("arst req_bytes", req_bytes, 0);
      chk("arst rsp_row", 32'(rsp_row), 0);
      repeat (2) sync();
      rstnn = 1'b1;
      repeat (3) sync();
      chk("arst no done", 32'(n_done), 32'(saved));

      // Recovery after reset
      log_q.delete();
      send(32'h8000, 16'h4, 3'd1, 3'd0, 3'd0);
      wait_done(100);
      chk("recover count", 32'(log_q.size()), 2);
      chk("recover addr1", log_q[1].addr, 32'h8004);

      repeat (3) sync();
      $display("[TB] %0d tests run, %0d failed",
               n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dca_matrix_block_row_requester.md
Name: dca_matrix_block_row_requester

Overview:
- Downstream of the matrix splitter. Accepts one block descriptor at a time and issues one memory read request per valid row of that block.
- Tracks outstanding read responses, which return in order.
- Pulses block_done once every row of the block has returned. The controller uses this pulse to advance the splitter.
- Sits between the splitter and the DCA load path, ahead of the row buffer.

Parameters:
- MATRIX_NUM_ROW, 8, rows per block tile; power of two, at least 1.
- MATRIX_NUM_COL, 8, columns per block tile; power of two, at least 1.
- BW_ADDR, 32, byte address width.
- BW_STRIDE, 16, row stride width in bytes.
- BW_ELEM_LOG2, 3, width of the element-size field (log2 of bytes per element).
- MAX_OUTSTANDING, 4, maximum number of in-flight row reads; at least 1.

Ports:
- clk  in  1  clock
- rstnn  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous abort; returns block to IDLE
- blk_valid  in  1  block descriptor valid
- blk_ready  out  1  block descriptor accepted
- blk_addr  in  BW_ADDR  byte address of the block's row 0, column 0
- blk_stride  in  BW_STRIDE  byte distance between consecutive rows
- blk_num_row_m1  in  LOG2RU(MATRIX_NUM_ROW)  valid rows minus 1
- blk_num_col_m1  in  LOG2RU(MATRIX_NUM_COL)  valid columns minus 1
- blk_elem_log2  in  BW_ELEM_LOG2  log2 of bytes per element
- req_valid  out  1  row read request valid
- req_ready  in  1  memory accepts the request
- req_addr  out  BW_ADDR  row start byte address
- req_bytes  out  BW_ADDR  row byte count
- req_row  out  LOG2RU(MATRIX_NUM_ROW)  row index within the block
- req_last  out  1  last row of the block
- rsp_valid  in  1  one row response returned, in order
- rsp_row  out  LOG2RU(MATRIX_NUM_ROW)  row index of the current response
- rsp_last  out  1  current response is the block's final row
- block_done  out  1  single-cycle pulse after the final response
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, except blk_ready=1.
  - Counters 0.
- States:
  - IDLE: blk_ready=1. On blk_valid, latch the descriptor, set issue_row=0, rsp_cnt=0, row_addr=blk_addr, and go to ISSUE. There is no request in the acceptance cycle, so the first req_valid appears one cycle after acceptance.
  - ISSUE: req_valid=1 iff outstanding<MAX_OUTSTANDING.
    - req_addr=row_addr.
    - req_row=issue_row.
    - req_bytes=(num_col_m1+1)<<elem_log2, zero-extended to BW_ADDR.
    - req_last=(issue_row==num_row_m1).
    - On req_valid&&req_ready: row_addr+=stride (zero-extended, modulo 2^BW_ADDR wrap) and issue_row++. If req_last, go to DRAIN.
  - DRAIN: no requests. Leave when the last response arrives.
- Request hold rule: once req_valid=1, req_valid and all request fields stay stable until the handshake completes.
- outstanding counter: +1 on request handshake, -1 on rsp_valid, unchanged when both occur in the same cycle.
- Illegal response: rsp_valid while outstanding==0 is illegal. An assertion fires, and the counter saturates at 0.
- Response tracking: rsp_row=rsp_cnt and rsp_last=(rsp_cnt==num_row_m1), both combinational and valid while busy. rsp_cnt increments on each rsp_valid.
- Block completion: on rsp_valid with rsp_last (in ISSUE or DRAIN), block_done=1 on the next cycle and the state returns to IDLE. blk_ready rises in that same cycle, so block-to-block turnaround is 1 idle cycle.
- Single-row block (num_row_m1=0): one request with req_last=1 is issued, then the block goes to DRAIN.
- The response for the last request may arrive in the same cycle as that request's handshake only if the memory has zero latency. This case is not supported; responses require at least 1 cycle.
- clear:
  - Has priority over all other events.
  - Next state IDLE; outstanding, issue_row and rsp_cnt set to 0; no block_done.
  - In-flight responses after clear are the upstream's responsibility to flush.
- Asynchronous reset mid-block: immediate return to the reset values; no partial block_done.
- Descriptor fields are sampled only in IDLE on acceptance. Changes while busy are ignored.

Decomposition:
- Shared package dca_matrix_pkg holds:
  - the descriptor field widths (address, stride, row/col minus-1, element log2);
  - the state encoding IDLE/ISSUE/DRAIN;
  - the helper LOG2RU.
- One natural sub-module: dca_outstanding_counter, an up/down counter with simultaneous-event handling, limit compare, and underflow assertion.

Test Plan:
- Full block: addr=0x1000, stride=0x40, num_row_m1=7, num_col_m1=7, elem_log2=2, req_ready=1, 2-cycle response latency -> 8 requests with addrs 0x1000…0x11C0, req_bytes=32, req_last only on row 7; block_done 1 cycle after the 8th rsp.
- Backpressure: MAX_OUTSTANDING=2, responses withheld -> exactly 2 requests issued, req_valid=0 afterwards; releasing one rsp permits one more request.
- Stall stability: req_ready=0 for 5 cycles with row 3 pending -> req_addr, req_row=3 and req_last=0 held unchanged; handshake on cycle 6.
- Edge block: num_row_m1=0, num_col_m1=2, elem_log2=0 -> single request, req_bytes=3, req_last=1, then DRAIN; block_done after the single rsp.
- Wrap and back-to-back: addr=0xFFFFFFC0, stride=0x40, 2 rows -> second req_addr=0x00000000; a second descriptor is held on blk_valid and accepted in the block_done cycle.
- Abort: clear asserted in DRAIN with 2 outstanding -> next cycle IDLE, busy=0, blk_ready=1, no block_done; async rstnn mid-ISSUE -> all outputs at reset values.
